// File: rtl/ps2_pkg.sv
// Shared constants, event type and frame check for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0]  PS2_BRK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_LEN  = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } ps2_state_t;

  // Frame layout after LSB-first shifting: [0] start, [8:1] data, [9] parity, [10] stop.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_LEN-1:0] frame);
    return !frame[0] && (^frame[9:1]) && frame[10];
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through event FIFO; head data reads as zero while empty.
module ps2_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host receiver: clock filter, frame FSM, timeout, prefix folding, event FIFO.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 6,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyb_clk,
  input  logic       keyb_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned HALF = FILTER_LEN / 2;
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_LEN - 1);

  logic [FILTER_LEN-1:0]    hist;
  logic                     fall;
  ps2_state_t               state;
  logic [3:0]               bit_cnt;
  logic [PS2_FRAME_LEN-1:0] shreg;
  logic [TW-1:0]            tcnt;
  logic                     ext_pend;
  logic                     brk_pend;

  logic                     frame_ok;
  logic [7:0]               rx_byte;
  logic                     is_prefix;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  ps2_event_t               ev_in;
  ps2_event_t               ev_out;

  // Raw keyboard clock history, newest sample at the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= '1;
    else       hist <= {keyb_clk, hist[FILTER_LEN-1:1]};
  end

  assign fall = (hist[FILTER_LEN-1:HALF] == '0) && (hist[HALF-1:0] == '1);

  assign frame_ok  = ps2_frame_ok(shreg);
  assign rx_byte   = shreg[8:1];
  assign is_prefix = (rx_byte == PS2_EXT_PREFIX) || (rx_byte == PS2_BRK_PREFIX);
  assign push      = (state == ST_CHECK) && frame_ok && !is_prefix;
  assign pop       = ev_valid && ev_ready;
  assign ev_in     = '{ext: ext_pend, brk: brk_pend, code: rx_byte};

  // Frame reception, timeout abort and prefix folding; error pulses are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (fall && !keyb_data) begin
            shreg   <= {keyb_data, shreg[PS2_FRAME_LEN-1:1]};
            bit_cnt <= 4'd1;
            state   <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (fall) begin
            shreg   <= {keyb_data, shreg[PS2_FRAME_LEN-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tcnt    <= '0;
            if (bit_cnt == LAST_BIT) state <= ST_CHECK;
          end else if (tcnt == TCNT_LAST) begin
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            tcnt      <= '0;
            state     <= ST_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          tcnt  <= '0;
          if (!frame_ok) begin
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end else if (rx_byte == PS2_EXT_PREFIX) begin
            ext_pend <= 1'b1;
          end else if (rx_byte == PS2_BRK_PREFIX) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (fifo_full && !pop) overflow <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ps2_rx_fifo #(
    .WIDTH($bits(ps2_event_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (ev_in),
    .pop   (pop),
    .rdata (ev_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = ev_out.code;
  assign ev_ext   = ev_out.ext;
  assign ev_brk   = ev_out.brk;

endmodule
